// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for a shared 4:1 datapath.
// Grants one requester at a time, bounds each tenure to MAX_HOLD cycles,
// and inserts one idle bubble after every release before regranting.
module rr_mux_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Last hold count value an owner may reach before a forced release.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] hold_cnt;

  logic [1:0] winner;
  logic       owner_req;
  logic       hold_expired;
  logic       release_now;

  // Pick the first set request bit starting at ptr and wrapping around.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    winner = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[2'(ptr + 2'(k))]) begin
        winner = 2'(ptr + 2'(k));
      end
    end
  end

  // Release conditions for the current owner while busy.
  always_comb begin
    owner_req    = req[sel];
    hold_expired = (hold_cnt == HOLD_LAST);
    release_now  = done || !owner_req || hold_expired;
  end

  // Arbitration state machine with registered grant outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values, regardless of statement order.
    if (rst) begin
      // NOTE: reset is synchronous; all state and outputs return to a
      // known idle configuration with the pointer at requester 0.
      state    <= IDLE;
      ptr      <= 2'd0;
      hold_cnt <= 8'd0;
      gnt      <= 4'b0000;
      sel      <= 2'b00;
      valid    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (req != 4'b0000) begin
            state    <= BUSY;
            gnt      <= 4'b0001 << winner;
            sel      <= winner;
            valid    <= 1'b1;
            hold_cnt <= 8'd0;
          end else begin
            gnt   <= 4'b0000;
            valid <= 1'b0;
          end
        end
        BUSY: begin
          if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
          if (release_now) begin
            state   <= IDLE;
            gnt     <= 4'b0000;
            valid   <= 1'b0;
            ptr     <= sel + 2'd1;
            // Only a pure hold expiry counts as forced.
            timeout <= hold_expired && owner_req && !done;
          end else begin
            timeout <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'b0000;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: three instances (MAX_HOLD 8, 4, 1) share the
// stimulus and are compared every cycle against a tenure-based model.
module tb_rr_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;

  logic [3:0] gnt0, gnt1, gnt2;
  logic [1:0] sel0, sel1, sel2;
  logic       valid0, valid1, valid2;
  logic       to0, to1, to2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.MAX_HOLD(8)) dut0 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt0), .sel(sel0), .valid(valid0), .timeout(to0));
  rr_mux_arbiter #(.MAX_HOLD(4)) dut1 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt1), .sel(sel1), .valid(valid1), .timeout(to1));
  rr_mux_arbiter #(.MAX_HOLD(1)) dut2 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt2), .sel(sel2), .valid(valid2), .timeout(to2));

  // Observed {gnt, sel, valid, timeout} per instance.
  logic [7:0] obs [3];
  assign obs[0] = {gnt0, sel0, valid0, to0};
  assign obs[1] = {gnt1, sel1, valid1, to1};
  assign obs[2] = {gnt2, sel2, valid2, to2};

  // Reference model: who owns the datapath and for how many cycles.
  int max_hold [3] = '{8, 4, 1};
  bit m_busy   [3];
  int m_owner  [3];
  int m_ptr    [3];
  int m_held   [3];
  int m_sel    [3];
  bit m_to     [3];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] expected(input int k);
    logic [3:0] g;
    g = m_busy[k] ? 4'(1 << m_owner[k]) : 4'b0000;
    return {g, 2'(m_sel[k]), m_busy[k], m_to[k]};
  endfunction

  // Advance the model by one clock edge with the currently driven inputs.
  task automatic model_edge(input int k);
    bit expire;
    if (rst) begin
      m_busy[k] = 0; m_ptr[k] = 0; m_held[k] = 0; m_sel[k] = 0; m_to[k] = 0;
    end else if (!m_busy[k]) begin
      m_to[k] = 0;
      if (req != 4'b0000) begin
        for (int i = 3; i >= 0; i--)
          if (req[(m_ptr[k] + i) % 4]) m_owner[k] = (m_ptr[k] + i) % 4;
        m_busy[k] = 1;
        m_sel[k]  = m_owner[k];
        m_held[k] = 0;
      end
    end else begin
      // This edge ends the owner's (m_held+1)-th cycle of tenure.
      expire = (m_held[k] + 1 >= max_hold[k]);
      m_held[k]++;
      if (done || !req[m_owner[k]] || expire) begin
        m_to[k]   = expire && req[m_owner[k]] && !done;
        m_busy[k] = 0;
        m_ptr[k]  = (m_owner[k] + 1) % 4;
      end else begin
        m_to[k] = 0;
      end
    end
  endtask

  task automatic step(input logic [3:0] r, input logic d, input logic rs);
    req  = r;
    done = d;
    rst  = rs;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      model_edge(k);
      check($sformatf("out%0d", k), 32'(obs[k]), 32'(expected(k)));
    end
    check("onehot0", 32'($onehot0(gnt0) && $onehot0(gnt1) && $onehot0(gnt2)), 32'd1);
    check("gnt_sel", 32'({gnt0[sel0], gnt1[sel1], gnt2[sel2]}),
          32'({valid0, valid1, valid2}));
  endtask

  initial begin
    req = 4'b0000; done = 1'b0; rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      m_busy[k] = 0; m_owner[k] = 0; m_ptr[k] = 0;
      m_held[k] = 0; m_sel[k] = 0; m_to[k] = 0;
    end

    // Reset state.
    step(4'b0000, 1'b0, 1'b1);
    check("reset_state", 32'(obs[0]), 32'h00);

    // Round-robin rotation with done pulsed in each grant cycle.
    begin
      logic [3:0] seq [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                              4'b0000, 4'b1000, 4'b0000, 4'b0001};
      for (int i = 0; i < 9; i++) begin
        step(4'b1111, seq[i] == 4'b0000, 1'b0);
        check($sformatf("rot_gnt%0d", i), 32'(gnt0), 32'(seq[i]));
        check($sformatf("rot_to%0d", i), 32'(to0), 32'd0);
      end
    end

    // Forced release after MAX_HOLD=8 cycles.
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(4'b0100, 1'b0, 1'b0);
      check($sformatf("hold_gnt%0d", i), 32'(gnt0), 32'h4);
    end
    step(4'b0100, 1'b0, 1'b0);
    check("forced_rel", 32'({gnt0, to0}), 32'({4'b0000, 1'b1}));
    step(4'b0100, 1'b0, 1'b0);
    check("forced_regrant", 32'({gnt0, to0}), 32'({4'b0100, 1'b0}));

    // Request drop by owner 1 in its third grant cycle, req[0] pending.
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0011, 1'b0, 1'b0);
    step(4'b0011, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    check("drop_rel", 32'({gnt0, to0}), 32'h0);
    step(4'b0001, 1'b0, 1'b0);
    check("drop_regrant", 32'(gnt0), 32'h1);

    // Reset while owner 3 holds the grant.
    step(4'b0000, 1'b0, 1'b1);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b1000, 1'b1, 1'b1);
    check("rst_busy", 32'(obs[0]), 32'h00);
    step(4'b1010, 1'b0, 1'b0);
    check("rst_first", 32'(gnt0), 32'h2);

    // Done coincides with hold expiry (MAX_HOLD=4 instance).
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    check("coincide", 32'({gnt1, to1}), 32'h0);
    step(4'b1111, 1'b0, 1'b0);
    check("coincide_ptr", 32'(gnt1), 32'h8);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 63) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
